mux_arbitro: RTL

MUX_ARBITRO -- requirements
Module: mux_arbitro

---
 rtl/mux_arbitro.sv | 112 +++++++++++
 1 files changed

// File: rtl/mux_arbitro.sv
// N-to-1 valid/ready multiplexer with a single output register slot.
// Channel choice is either a fixed index (mode=0) or round-robin from a rotating pointer (mode=1).
module mux_arbitro #(
    parameter  int N = 4,
    parameter  int W = 8,
    localparam int S = (N > 2) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [S-1:0]   sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [S-1:0]   out_ch,
    input  logic           out_ready
);

    logic [S-1:0]   r_ptr;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic [S-1:0]   r_out_ch;

    logic           w_grant_vld;
    logic [S-1:0]   w_grant_idx;
    logic [W-1:0]   w_grant_data;
    logic [S-1:0]   w_ptr_next;
    logic           w_slot_free;
    logic           w_in_xfer;
    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_req_rot;
    logic [S:0]     w_sum;

    // Rotating the doubled request vector by ptr puts the search start at bit 0,
    // so the lowest set bit k maps back to channel (ptr + k) mod N.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_req_dbl   = {in_valid, in_valid};
        w_req_rot   = N'(w_req_dbl >> r_ptr);
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == S'(i) && in_valid[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = S'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (w_req_rot[k]) begin
                    w_grant_vld = 1'b1;
                    w_sum       = {1'b0, r_ptr} + (S+1)'(k);
                    if (w_sum >= (S+1)'(N)) begin
                        w_sum = w_sum - (S+1)'(N);
                    end
                    w_grant_idx = w_sum[S-1:0];
                end
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == S'(i)) begin
                w_grant_data = in_data[i*W +: W];
            end
        end
    end

    assign w_ptr_next  = (w_grant_idx == S'(N - 1)) ? '0 : w_grant_idx + S'(1);
    // rst_n gates the slot so in_ready drops asynchronously with reset.
    assign w_slot_free = rst_n && (!r_out_valid || out_ready);
    assign w_in_xfer   = w_slot_free && w_grant_vld;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = w_in_xfer && (w_grant_idx == S'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_ch    <= w_grant_idx;
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule
